// File: rtl/core_mem_pkg.sv
// core_mem_pkg: shared master IDs, request struct and constants for the core memory arbiter
package core_mem_pkg;
    typedef enum logic {MST_INSTR = 1'b0, MST_DATA = 1'b1} mst_id_e;
    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } mem_req_t;
    localparam logic [3:0] INSTR_BE = 4'hF;
endpackage

// File: rtl/core_mem_id_fifo.sv
// core_mem_id_fifo: records which master owns each outstanding transaction, oldest at head
module core_mem_id_fifo
    import core_mem_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk_i,
    input  logic    rst_i,
    input  logic    push,
    input  logic    pop,
    input  mst_id_e push_id,
    output logic    full,
    output logic    empty,
    output mst_id_e head
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    logic [PW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;
    mst_id_e       mem_q [2**PW];
    // Pointers wrap explicitly so non-power-of-two depths work
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) wr_q <= (wr_q == LAST) ? '0 : wr_q + 1'b1;
            if (pop) rd_q <= (rd_q == LAST) ? '0 : rd_q + 1'b1;
            cnt_q <= cnt_q + CW'(push) - CW'(pop);
        end
    end
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_q] <= push_id;
    end
    assign full  = cnt_q == FULL_CNT;
    assign empty = cnt_q == '0;
    assign head  = mem_q[rd_q];
endmodule

// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter: shares one req/gnt/rvalid memory port between fetch and data masters
module core_mem_arbiter
    import core_mem_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    parameter bit DATA_PRIO       = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    input  logic        data_req_i,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i,
    output logic        protocol_err_o
);
    mst_id_e  last_q, sel_q, sel, head;
    logic     lock_q, perr_q, fifo_full, fifo_empty, sel_req, accept, rsp_ok;
    mem_req_t instr_mreq, data_mreq, mreq;
    // Full blocks new requests even on a same-cycle pop, keeping rvalid off the req path
    always_comb begin
        instr_mreq = '{addr: instr_addr_i, we: 1'b0, be: INSTR_BE, wdata: 32'h0};
        data_mreq  = '{addr: data_addr_i, we: data_we_i, be: data_be_i, wdata: data_wdata_i};
        sel        = lock_q ? sel_q
                   : (instr_req_i && data_req_i) ? ((DATA_PRIO || last_q == MST_INSTR) ? MST_DATA : MST_INSTR)
                   : (data_req_i ? MST_DATA : MST_INSTR);
        sel_req    = (sel == MST_DATA) ? data_req_i : instr_req_i;
        mreq       = !sel_req ? '0 : ((sel == MST_DATA) ? data_mreq : instr_mreq);
        mem_req_o  = sel_req && !fifo_full && !rst_i;
        accept     = mem_req_o && mem_gnt_i;
        rsp_ok     = mem_rvalid_i && !fifo_empty && !rst_i;
    end
    assign mem_addr_o     = mreq.addr;
    assign mem_we_o       = mreq.we;
    assign mem_be_o       = mreq.be;
    assign mem_wdata_o    = mreq.wdata;
    assign instr_gnt_o    = accept && sel == MST_INSTR;
    assign data_gnt_o     = accept && sel == MST_DATA;
    assign instr_rvalid_o = rsp_ok && head == MST_INSTR;
    assign data_rvalid_o  = rsp_ok && head == MST_DATA;
    assign data_err_o     = data_rvalid_o && mem_err_i;
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;
    assign protocol_err_o = perr_q;
    // A stalled request pins the selection so the slave sees a stable address
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lock_q <= 1'b0;
            sel_q  <= MST_INSTR;
            last_q <= MST_INSTR;
            perr_q <= 1'b0;
        end else begin
            lock_q <= mem_req_o && !mem_gnt_i;
            sel_q  <= sel;
            if (accept) last_q <= sel;
            if (mem_rvalid_i && fifo_empty) perr_q <= 1'b1;
        end
    end
    core_mem_id_fifo #(.DEPTH(MAX_OUTSTANDING)) u_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push    (accept),
        .pop     (rsp_ok),
        .push_id (sel),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (head)
    );
endmodule

// File: tb/tb_core_mem_arbiter.sv
// tb_core_mem_arbiter: directed scenarios plus randomized traffic against a queue-based reference model
module tb_core_mem_arbiter;
    localparam int MAXO = 2;
    logic        clk_i = 1'b0, rst_i = 1'b1;
    logic        instr_req_i, data_req_i, data_we_i, mem_gnt_i, mem_rvalid_i, mem_err_i;
    logic [31:0] instr_addr_i, data_addr_i, data_wdata_i, mem_rdata_i;
    logic [3:0]  data_be_i;
    logic        instr_gnt_o, instr_rvalid_o, data_gnt_o, data_rvalid_o, data_err_o;
    logic        mem_req_o, mem_we_o, protocol_err_o;
    logic [31:0] instr_rdata_o, data_rdata_o, mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        p_instr_gnt, p_instr_rvalid, p_data_gnt, p_data_rvalid, p_data_err;
    logic        p_mem_req, p_mem_we, p_perr;
    logic [31:0] p_instr_rdata, p_data_rdata, p_mem_addr, p_mem_wdata;
    logic [3:0]  p_mem_be;
    int compared = 0, mismatched = 0;

    core_mem_arbiter #(.MAX_OUTSTANDING(MAXO), .DATA_PRIO(1'b0)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
        .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
        .data_req_i(data_req_i), .data_addr_i(data_addr_i), .data_we_i(data_we_i),
        .data_be_i(data_be_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
        .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i), .protocol_err_o(protocol_err_o)
    );

    core_mem_arbiter #(.MAX_OUTSTANDING(2), .DATA_PRIO(1'b1)) dut_p (
        .clk_i(clk_i), .rst_i(rst_i),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(p_instr_gnt),
        .instr_rvalid_o(p_instr_rvalid), .instr_rdata_o(p_instr_rdata),
        .data_req_i(data_req_i), .data_addr_i(data_addr_i), .data_we_i(data_we_i),
        .data_be_i(data_be_i), .data_wdata_i(data_wdata_i), .data_gnt_o(p_data_gnt),
        .data_rvalid_o(p_data_rvalid), .data_rdata_o(p_data_rdata), .data_err_o(p_data_err),
        .mem_req_o(p_mem_req), .mem_addr_o(p_mem_addr), .mem_we_o(p_mem_we), .mem_be_o(p_mem_be),
        .mem_wdata_o(p_mem_wdata), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i), .protocol_err_o(p_perr)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        instr_req_i = 0; instr_addr_i = 0; data_req_i = 0; data_addr_i = 0; data_we_i = 0;
        data_be_i = 0; data_wdata_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0; mem_err_i = 0;
    endtask

    task automatic reset_pulse();
        @(negedge clk_i); idle(); rst_i = 1;
        @(negedge clk_i); rst_i = 0;
    endtask

    initial begin
        int q[$];
        int last, lsel, pick, head;
        bit locked, perr, ip, dp, sreq, ereq, egnt, erv;
        logic [31:0] eaddr;
        // reset: outputs forced low even with requests and rvalid present
        idle(); instr_req_i = 1; data_req_i = 1; mem_gnt_i = 1; mem_rvalid_i = 1; rst_i = 1;
        repeat (2) @(negedge clk_i);
        #1;
        chk("rst_mem_req", mem_req_o, 0);
        chk("rst_igrant", instr_gnt_o, 0);
        chk("rst_dgrant", data_gnt_o, 0);
        chk("rst_irvalid", instr_rvalid_o, 0);
        chk("rst_drvalid", data_rvalid_o, 0);
        chk("rst_perr", protocol_err_o, 0);
        @(negedge clk_i); idle(); rst_i = 0;

        // data only
        @(negedge clk_i); data_req_i = 1; data_we_i = 1; data_addr_i = 32'h100; data_be_i = 4'h3;
        data_wdata_i = 32'hCAFE; mem_gnt_i = 1; #1;
        chk("d_req", mem_req_o, 1); chk("d_we", mem_we_o, 1); chk("d_be", mem_be_o, 4'h3);
        chk("d_addr", mem_addr_o, 32'h100); chk("d_wdata", mem_wdata_o, 32'hCAFE);
        chk("d_gnt", data_gnt_o, 1); chk("d_igrant", instr_gnt_o, 0);
        @(negedge clk_i); idle(); mem_rvalid_i = 1; mem_rdata_i = 32'h55; #1;
        chk("d_rvalid", data_rvalid_o, 1); chk("d_irvalid", instr_rvalid_o, 0);
        chk("d_rdata", data_rdata_o, 32'h55); chk("d_idle_req", mem_req_o, 0); chk("d_idle_addr", mem_addr_o, 0);

        // round-robin vs data priority, both masters requesting continuously
        reset_pulse();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            instr_req_i = 1; data_req_i = 1; instr_addr_i = 32'h40; data_addr_i = 32'h200;
            data_we_i = 1; data_be_i = 4'h5; data_wdata_i = 32'h1234; mem_gnt_i = 1;
            mem_rvalid_i = (k > 0); #1;
            chk("rr_dgnt", data_gnt_o, (k % 2) == 0);
            chk("rr_ignt", instr_gnt_o, (k % 2) == 1);
            chk("rr_addr", mem_addr_o, (k % 2) ? 32'h40 : 32'h200);
            chk("rr_we", mem_we_o, (k % 2) == 0);
            chk("rr_be", mem_be_o, (k % 2) ? 32'hF : 32'h5);
            chk("rr_wdata", mem_wdata_o, (k % 2) ? 32'h0 : 32'h1234);
            chk("prio_dgnt", p_data_gnt, 1);
            chk("prio_ignt", p_instr_gnt, 0);
            if (k > 0) begin
                chk("rr_drv", data_rvalid_o, ((k - 1) % 2) == 0);
                chk("rr_irv", instr_rvalid_o, ((k - 1) % 2) == 1);
            end
        end
        @(negedge clk_i); idle(); mem_rvalid_i = 1; #1;
        chk("rr_last_irv", instr_rvalid_o, 1); chk("prio_last_drv", p_data_rvalid, 1);

        // lock: instruction stalled, data arrives meanwhile
        @(negedge clk_i); idle(); instr_req_i = 1; instr_addr_i = 32'h80; #1;
        chk("lk_req", mem_req_o, 1); chk("lk_addr0", mem_addr_o, 32'h80); chk("lk_ignt0", instr_gnt_o, 0);
        @(negedge clk_i); data_req_i = 1; data_addr_i = 32'h300; #1;
        chk("lk_addr1", mem_addr_o, 32'h80); chk("lk_dgnt1", data_gnt_o, 0);
        @(negedge clk_i); #1;
        chk("lk_addr2", mem_addr_o, 32'h80);
        @(negedge clk_i); mem_gnt_i = 1; #1;
        chk("lk_addr3", mem_addr_o, 32'h80); chk("lk_ignt3", instr_gnt_o, 1); chk("lk_dgnt3", data_gnt_o, 0);
        @(negedge clk_i); instr_req_i = 0; #1;
        chk("lk_addr4", mem_addr_o, 32'h300); chk("lk_dgnt4", data_gnt_o, 1);
        @(negedge clk_i); idle(); mem_rvalid_i = 1; #1;
        chk("lk_irv", instr_rvalid_o, 1);
        @(negedge clk_i); #1;
        chk("lk_drv", data_rvalid_o, 1);

        // full FIFO blocks requests, including on the pop cycle
        @(negedge clk_i); idle(); data_req_i = 1; data_addr_i = 32'h10; mem_gnt_i = 1; #1;
        chk("f_req0", mem_req_o, 1); chk("f_gnt0", data_gnt_o, 1);
        @(negedge clk_i); data_addr_i = 32'h14; #1;
        chk("f_gnt1", data_gnt_o, 1);
        @(negedge clk_i); #1;
        chk("f_req2", mem_req_o, 0); chk("f_gnt2", data_gnt_o, 0);
        @(negedge clk_i); mem_rvalid_i = 1; #1;
        chk("f_req3", mem_req_o, 0); chk("f_rv3", data_rvalid_o, 1);
        @(negedge clk_i); mem_rvalid_i = 0; #1;
        chk("f_req4", mem_req_o, 1); chk("f_gnt4", data_gnt_o, 1);
        @(negedge clk_i); idle(); mem_rvalid_i = 1; #1;
        chk("f_rv5", data_rvalid_o, 1);
        @(negedge clk_i); #1;
        chk("f_rv6", data_rvalid_o, 1);

        // responses routed by issue order, error only reported for data
        @(negedge clk_i); idle(); instr_req_i = 1; instr_addr_i = 32'h8; mem_gnt_i = 1; #1;
        chk("o_ignt", instr_gnt_o, 1);
        @(negedge clk_i); instr_req_i = 0; data_req_i = 1; data_addr_i = 32'h20; #1;
        chk("o_dgnt", data_gnt_o, 1);
        @(negedge clk_i); idle(); mem_rvalid_i = 1; mem_rdata_i = 32'h13; mem_err_i = 1; #1;
        chk("o_irv", instr_rvalid_o, 1); chk("o_irdata", instr_rdata_o, 32'h13);
        chk("o_drv0", data_rvalid_o, 0); chk("o_derr0", data_err_o, 0);
        @(negedge clk_i); mem_rdata_i = 32'hDEAD; #1;
        chk("o_drv", data_rvalid_o, 1); chk("o_drdata", data_rdata_o, 32'hDEAD);
        chk("o_derr", data_err_o, 1); chk("o_irv1", instr_rvalid_o, 0);

        // protocol error is sticky; async reset clears it without a clock edge
        @(negedge clk_i); idle(); mem_rvalid_i = 1; #1;
        chk("pe_irv", instr_rvalid_o, 0); chk("pe_drv", data_rvalid_o, 0); chk("pe_pre", protocol_err_o, 0);
        @(negedge clk_i); mem_rvalid_i = 0; #1;
        chk("pe_set", protocol_err_o, 1);
        @(negedge clk_i); data_req_i = 1; data_addr_i = 32'h44; #1;
        chk("pe_hold", protocol_err_o, 1); chk("pe_req", mem_req_o, 1);
        #2 rst_i = 1;
        #1;
        chk("ar_perr", protocol_err_o, 0); chk("ar_req", mem_req_o, 0);
        @(negedge clk_i); idle(); rst_i = 0;

        // randomized traffic against a transaction-queue model
        reset_pulse();
        last = 0; lsel = 0; locked = 0; perr = 0; ip = 0; dp = 0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk_i);
            if (!ip) begin ip = 1'($urandom_range(0, 1)); instr_addr_i = $urandom; end
            if (!dp) begin
                dp = 1'($urandom_range(0, 1)); data_addr_i = $urandom; data_we_i = 1'($urandom);
                data_be_i = 4'($urandom); data_wdata_i = $urandom;
            end
            instr_req_i = ip; data_req_i = dp;
            mem_gnt_i = $urandom_range(0, 3) != 0;
            mem_rvalid_i = (q.size() > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 63) == 0);
            mem_rdata_i = $urandom; mem_err_i = 1'($urandom);
            #1;
            pick = locked ? lsel : (ip && dp) ? (last == 0 ? 1 : 0) : (dp ? 1 : 0);
            sreq = pick == 1 ? dp : ip;
            ereq = sreq && q.size() < MAXO;
            egnt = ereq && mem_gnt_i;
            eaddr = !sreq ? 32'h0 : (pick == 1 ? data_addr_i : instr_addr_i);
            erv = mem_rvalid_i && q.size() > 0;
            head = q.size() > 0 ? q[0] : -1;
            chk("rnd_req", mem_req_o, ereq);
            chk("rnd_addr", mem_addr_o, eaddr);
            chk("rnd_we", mem_we_o, sreq && pick == 1 && data_we_i);
            chk("rnd_ignt", instr_gnt_o, egnt && pick == 0);
            chk("rnd_dgnt", data_gnt_o, egnt && pick == 1);
            chk("rnd_irv", instr_rvalid_o, erv && head == 0);
            chk("rnd_drv", data_rvalid_o, erv && head == 1);
            chk("rnd_derr", data_err_o, erv && head == 1 && mem_err_i);
            chk("rnd_rdata", data_rdata_o, mem_rdata_i);
            chk("rnd_perr", protocol_err_o, perr);
            if (erv) void'(q.pop_front());
            else if (mem_rvalid_i) perr = 1;
            if (egnt) begin
                q.push_back(pick);
                last = pick;
                if (pick == 1) dp = 0; else ip = 0;
            end
            locked = ereq && !mem_gnt_i;
            lsel = pick;
        end
        @(negedge clk_i); idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
